// File: rtl/capture_pkg.sv
// Shared types and default sizing for the DSO capture controller.
package capture_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PRE  = 2'd1,
    POST = 2'd2,
    DONE = 2'd3
  } capture_state_t;

  localparam int ENTRIES_DEFAULT = 512;
  localparam int AW_DEFAULT      = 9;

endpackage

// File: rtl/sample_strobe_gen.sv
// Decimation strobe for the capture controller: smp fires once every
// 2^decim clocks, counting from the cycle after restart. Only used when
// the design is built with CAPTURE_DECIM_EN.
module sample_strobe_gen (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       restart,
  input  logic [3:0] decim,
  output logic       smp
);

  logic [14:0] div_cnt;
  logic [3:0]  dec_q;
  logic [14:0] div_mask;

  // Free-running divider, realigned and given a fresh exponent on every capture start
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt <= '0;
      dec_q   <= '0;
    end else if (restart) begin
      div_cnt <= '0;
      dec_q   <= decim;
    end else begin
      div_cnt <= div_cnt + 15'd1;
    end
  end

  // A shift of 15 overflows to zero, so the mask becomes all ones (period 2^15)
  assign div_mask = (15'd1 << dec_q) - 15'd1;
  assign smp      = ((div_cnt & div_mask) == 15'd0);

endmodule

// File: rtl/capture_ctrl.sv
// Capture controller for the DSO sample RAM: sequences pre-trigger fill,
// trigger acceptance and post-trigger fill with circular write addresses.
// Build option CAPTURE_DECIM_EN: writes only on a decimated sample strobe.
module capture_ctrl
  import capture_pkg::*;
#(
  parameter int ENTRIES = ENTRIES_DEFAULT,
  parameter int AW      = AW_DEFAULT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          run,
  input  logic          abort,
  input  logic          done_ack,
  input  logic          triggered,
  input  logic [AW-1:0] trig_pos,
  input  logic [3:0]    decim,
  output logic          trig_en,
  output logic          armed,
  output logic          set_capture_done,
  output logic          we,
  output logic [AW-1:0] waddr,
  output logic [AW-1:0] trig_addr,
  output logic          capture_done,
  output logic          busy
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(ENTRIES);

  capture_state_t state, state_nxt;
  logic [AW-1:0]  tp;
  logic [AW-1:0]  pc;
  logic [AW:0]    cnt;
  logic [AW:0]    arm_thresh;
  logic           smp;
  logic           start;
  logic           accept;

`ifdef CAPTURE_DECIM_EN
  sample_strobe_gen u_strobe (
    .clk     (clk),
    .rst_n   (rst_n),
    .restart (start),
    .decim   (decim),
    .smp     (smp)
  );
`else
  logic unused_decim;
  assign unused_decim = ^decim;
  assign smp          = 1'b1;
`endif

  // Armed once enough pre-trigger samples exist to fill the rest of the RAM
  assign arm_thresh   = CNT_FULL - {1'b0, tp};
  assign armed        = (state == PRE) && (cnt >= arm_thresh);
  assign trig_en      = (state == PRE);
  assign capture_done = (state == DONE);
  assign busy         = (state != IDLE);

  // State register plus address, fill and post-trigger counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      tp        <= '0;
      pc        <= '0;
      cnt       <= '0;
      waddr     <= '0;
      trig_addr <= '0;
    end else begin
      state <= state_nxt;
      if (start) begin
        tp  <= trig_pos;
        cnt <= '0;
      end
      if (we) begin
        waddr <= waddr + AW'(1);
      end
      if ((state == PRE) && we && (cnt != CNT_FULL)) begin
        cnt <= cnt + (AW+1)'(1);
      end
      if (accept) begin
        trig_addr <= waddr;
        pc        <= tp;
      end
      if ((state == POST) && we) begin
        pc <= pc - AW'(1);
      end
    end
  end

  // Next-state and strobe decode; abort outranks trigger and acknowledge
  always_comb begin
    state_nxt        = state;
    we               = 1'b0;
    set_capture_done = 1'b0;
    start            = 1'b0;
    accept           = 1'b0;
    case (state)
      IDLE: begin
        if (run && !abort) begin
          start     = 1'b1;
          state_nxt = PRE;
        end
      end
      PRE: begin
        if (abort) begin
          set_capture_done = 1'b1;
          state_nxt        = IDLE;
        end else if (triggered && armed) begin
          accept    = 1'b1;
          state_nxt = POST;
        end else if (smp) begin
          we = 1'b1;
        end
      end
      POST: begin
        if (abort) begin
          set_capture_done = 1'b1;
          state_nxt        = IDLE;
        end else if (pc == '0) begin
          set_capture_done = 1'b1;
          state_nxt        = DONE;
        end else if (smp) begin
          we = 1'b1;
          if (pc == AW'(1)) begin
            set_capture_done = 1'b1;
            state_nxt        = DONE;
          end
        end
      end
      DONE: begin
        if (abort) begin
          set_capture_done = 1'b1;
          state_nxt        = IDLE;
        end else if (done_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
